// File: rtl/spi_regmap_pkg.sv
// Register map shared by the SPI decoder, the sequencer and the config bank.
// Address constants, highest valid address and the duty-commit FSM state type.
package spi_regmap_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_DUTY      = 7'd4;

  localparam int MAX_ADDR = 4;

  typedef enum logic {
    DUTY_IDLE    = 1'b0,
    DUTY_PENDING = 1'b1
  } duty_state_t;

endpackage

// File: rtl/wr_priority_arb.sv
// Two-port write arbiter: port 0 has fixed priority, port 1 is forced through
// after STARVE_LIMIT consecutive lost cycles. Grant is combinational.
module wr_priority_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic [1:0] grant
);

  logic [3:0] starve_cnt;
  logic       force1;

  assign force1 = req0_valid && req1_valid && (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    grant = 2'b00;
    if (force1)          grant = 2'b10;
    else if (req0_valid) grant = 2'b01;
    else if (req1_valid) grant = 2'b10;
  end

  // Counts consecutive cycles port 1 waits; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= 4'd0;
    else if (!req1_valid || grant[1])
      starve_cnt <= 4'd0;
    else if (starve_cnt != 4'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 4'd1;
  end

endmodule

// File: rtl/cfg_bank_arbiter.sv
// Five-entry config bank written by two arbitrated ports; duty cycle is staged
// in a shadow and committed on period_start so PWM never changes mid-period.
module cfg_bank_arbiter
  import spi_regmap_pkg::*;
#(
  parameter int MAX_ADDR     = spi_regmap_pkg::MAX_ADDR,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       period_start,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       duty_pending,
  output logic       wr_err,
  output logic       wr_err_src
);

  logic [1:0]  grant;
  logic        wr_vld;
  logic        wr_port;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        in_range;
  logic        duty_wr;
  logic [7:0]  duty_shadow;
  duty_state_t state, next_state;
  logic        commit_bypass;
  logic        commit_shadow;

  wr_priority_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign wr_vld     = |grant;
  assign wr_port    = grant[1];
  assign wr_addr    = grant[1] ? req1_addr : req0_addr;
  assign wr_data    = grant[1] ? req1_data : req0_data;
  assign in_range   = (wr_addr <= 7'(MAX_ADDR));
  assign duty_wr    = wr_vld && in_range && (wr_addr == ADDR_DUTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'd0;
      en_reg_out_15_8 <= 8'd0;
      en_reg_pwm_7_0  <= 8'd0;
      en_reg_pwm_15_8 <= 8'd0;
      wr_err          <= 1'b0;
      wr_err_src      <= 1'b0;
    end else begin
      wr_err <= wr_vld && !in_range;
      if (wr_vld && !in_range)
        wr_err_src <= wr_port;
      if (wr_vld && in_range) begin
        case (wr_addr)
          ADDR_EN_OUT_LO: en_reg_out_7_0  <= wr_data;
          ADDR_EN_OUT_HI: en_reg_out_15_8 <= wr_data;
          ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= wr_data;
          ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= wr_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DUTY_IDLE;
    else        state <= next_state;
  end

  // A duty write landing on period_start bypasses the shadow entirely.
  always_comb begin
    next_state    = state;
    commit_bypass = 1'b0;
    commit_shadow = 1'b0;
    case (state)
      DUTY_IDLE: begin
        if (duty_wr && period_start) commit_bypass = 1'b1;
        else if (duty_wr)            next_state    = DUTY_PENDING;
      end
      DUTY_PENDING: begin
        if (duty_wr && period_start) begin
          commit_bypass = 1'b1;
          next_state    = DUTY_IDLE;
        end else if (period_start) begin
          commit_shadow = 1'b1;
          next_state    = DUTY_IDLE;
        end
      end
      default: next_state = DUTY_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow    <= 8'd0;
      pwm_duty_cycle <= 8'd0;
    end else begin
      if (duty_wr && !period_start) duty_shadow <= wr_data;
      if (commit_bypass)            pwm_duty_cycle <= wr_data;
      else if (commit_shadow)       pwm_duty_cycle <= duty_shadow;
    end
  end

  assign duty_pending = (state == DUTY_PENDING);

endmodule

// File: tb/tb_cfg_bank_arbiter.sv
// Directed scenarios plus a randomized run against a register-level model of the bank.
module tb_cfg_bank_arbiter;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, period_start = 1'b0;
  logic [6:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       duty_pending, wr_err, wr_err_src;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic r0, r1;

  cfg_bank_arbiter #(.MAX_ADDR(4), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .period_start(period_start),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .duty_pending(duty_pending),
    .wr_err(wr_err), .wr_err_src(wr_err_src)
  );

  always #5 clk = ~clk;

  // Drive one cycle from a negedge, capture readies, return at the next negedge.
  task automatic cyc(input logic v0, input logic [6:0] a0, input logic [7:0] d0,
                     input logic v1, input logic [6:0] a1, input logic [7:0] d1,
                     input logic ps);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    period_start = ps;
    #1;
    r0 = req0_ready; r1 = req1_ready;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; period_start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b exp 00", {req0_ready, req1_ready}); else pass_cnt++;
    total_cnt++; if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'd0)
      $display("FAIL reset_regs: got %h exp 0", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}); else pass_cnt++;
    total_cnt++; if ({duty_pending, wr_err, wr_err_src} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {duty_pending, wr_err, wr_err_src}); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_direct;
    cyc(1'b1, 7'd2, 8'hA5, 1'b0, 7'd0, 8'h00, 1'b0);
    total_cnt++; if ({r0, r1} !== 2'b10) $display("FAIL direct_p0_ready: got %b exp 10", {r0, r1}); else pass_cnt++;
    total_cnt++; if (en_reg_pwm_7_0 !== 8'hA5) $display("FAIL direct_p0_data: got %h exp a5", en_reg_pwm_7_0); else pass_cnt++;
    cyc(1'b0, 7'd0, 8'h00, 1'b1, 7'd1, 8'h3C, 1'b0);
    total_cnt++; if ({r0, r1} !== 2'b01) $display("FAIL direct_p1_ready: got %b exp 01", {r0, r1}); else pass_cnt++;
    total_cnt++; if ({en_reg_out_15_8, en_reg_pwm_7_0} !== 16'h3CA5) $display("FAIL direct_p1_data: got %h exp 3ca5", {en_reg_out_15_8, en_reg_pwm_7_0}); else pass_cnt++;
  endtask

  task automatic test_starve;
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic exp1;
      exp1 = (i == 4) || (i == 9);
      cyc(1'b1, 7'd0, 8'(i), 1'b1, 7'd1, 8'(8'h80 + i), 1'b0);
      total_cnt++; if ({r0, r1} !== {!exp1, exp1}) $display("FAIL starve_grant cyc%0d: got %b exp %b", i, {r0, r1}, {!exp1, exp1}); else pass_cnt++;
    end
    total_cnt++; if ({en_reg_out_7_0, en_reg_out_15_8} !== 16'h0889) $display("FAIL starve_regs: got %h exp 0889", {en_reg_out_7_0, en_reg_out_15_8}); else pass_cnt++;
  endtask

  task automatic test_oor;
    logic [39:0] snap;
    snap = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
    cyc(1'b0, 7'd0, 8'h00, 1'b1, 7'd7, 8'hFF, 1'b0);
    total_cnt++; if (r1 !== 1'b1) $display("FAIL oor_ready: got %b exp 1", r1); else pass_cnt++;
    total_cnt++; if ({wr_err, wr_err_src} !== 2'b11) $display("FAIL oor_err_p1: got %b exp 11", {wr_err, wr_err_src}); else pass_cnt++;
    total_cnt++; if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== snap)
      $display("FAIL oor_regs: got %h exp %h", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}, snap); else pass_cnt++;
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b0);
    total_cnt++; if ({wr_err, wr_err_src} !== 2'b01) $display("FAIL oor_pulse: got %b exp 01", {wr_err, wr_err_src}); else pass_cnt++;
    cyc(1'b1, 7'd5, 8'h12, 1'b0, 7'd0, 8'h00, 1'b0);
    total_cnt++; if ({r0, wr_err, wr_err_src, duty_pending} !== 4'b1100) $display("FAIL oor_p0_addr5: got %b exp 1100", {r0, wr_err, wr_err_src, duty_pending}); else pass_cnt++;
  endtask

  task automatic test_duty_stage;
    cyc(1'b1, 7'd4, 8'h40, 1'b0, 7'd0, 8'h00, 1'b0);
    total_cnt++; if ({pwm_duty_cycle, duty_pending} !== {8'h00, 1'b1}) $display("FAIL stage_first: got %h/%b exp 00/1", pwm_duty_cycle, duty_pending); else pass_cnt++;
    cyc(1'b0, 7'd0, 8'h00, 1'b1, 7'd4, 8'h80, 1'b0);
    total_cnt++; if ({pwm_duty_cycle, duty_pending} !== {8'h00, 1'b1}) $display("FAIL stage_second: got %h/%b exp 00/1", pwm_duty_cycle, duty_pending); else pass_cnt++;
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1);
    total_cnt++; if ({pwm_duty_cycle, duty_pending} !== {8'h80, 1'b0}) $display("FAIL stage_commit: got %h/%b exp 80/0", pwm_duty_cycle, duty_pending); else pass_cnt++;
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1);
    total_cnt++; if ({pwm_duty_cycle, duty_pending} !== {8'h80, 1'b0}) $display("FAIL stage_idle_period: got %h/%b exp 80/0", pwm_duty_cycle, duty_pending); else pass_cnt++;
  endtask

  task automatic test_duty_bypass;
    cyc(1'b1, 7'd4, 8'h22, 1'b0, 7'd0, 8'h00, 1'b1);
    total_cnt++; if ({pwm_duty_cycle, duty_pending} !== {8'h22, 1'b0}) $display("FAIL bypass_idle: got %h/%b exp 22/0", pwm_duty_cycle, duty_pending); else pass_cnt++;
    cyc(1'b1, 7'd4, 8'h33, 1'b0, 7'd0, 8'h00, 1'b0);
    cyc(1'b0, 7'd0, 8'h00, 1'b1, 7'd4, 8'h44, 1'b1);
    total_cnt++; if ({pwm_duty_cycle, duty_pending} !== {8'h44, 1'b0}) $display("FAIL bypass_pending: got %h/%b exp 44/0", pwm_duty_cycle, duty_pending); else pass_cnt++;
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1);
    total_cnt++; if (pwm_duty_cycle !== 8'h44) $display("FAIL bypass_after: got %h exp 44", pwm_duty_cycle); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 7'd0, 8'h11, 1'b0, 7'd0, 8'h00, 1'b0);
    cyc(1'b0, 7'd0, 8'h00, 1'b1, 7'd4, 8'h55, 1'b0);
    cyc(1'b0, 7'd0, 8'h00, 1'b1, 7'd9, 8'h66, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'd0)
      $display("FAIL midreset_regs: got %h exp 0", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}); else pass_cnt++;
    total_cnt++; if ({duty_pending, wr_err, wr_err_src, req0_ready, req1_ready} !== 5'b0)
      $display("FAIL midreset_flags: got %b exp 00000", {duty_pending, wr_err, wr_err_src, req0_ready, req1_ready}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 7'd3, 8'h77, 1'b0, 7'd0, 8'h00, 1'b0);
    total_cnt++; if ({r0, en_reg_pwm_15_8} !== {1'b1, 8'h77}) $display("FAIL midreset_first_wr: got %b/%h exp 1/77", r0, en_reg_pwm_15_8); else pass_cnt++;
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1);
    total_cnt++; if ({pwm_duty_cycle, duty_pending} !== {8'h00, 1'b0}) $display("FAIL midreset_shadow_lost: got %h/%b exp 00/0", pwm_duty_cycle, duty_pending); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [7:0] m_reg [4];
    logic [7:0] m_duty, m_shadow;
    logic       m_pend, m_err, m_src;
    int         lost;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) m_reg[k] = 8'h00;
    m_duty = 8'h00; m_shadow = 8'h00; m_pend = 1'b0; m_err = 1'b0; m_src = 1'b0; lost = 0;
    for (int n = 0; n < 400; n++) begin
      logic v0, v1, ps, w0, w1, wr4;
      logic [6:0] a0, a1, a;
      logic [7:0] d0, d1, d;
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      ps = ($urandom_range(0, 3) == 0);
      a0 = 7'($urandom_range(0, 6)); if (a0 == 7'd6) a0 = 7'($urandom_range(5, 127));
      a1 = 7'($urandom_range(0, 6)); if (a1 == 7'd6) a1 = 7'($urandom_range(5, 127));
      d0 = 8'($urandom); d1 = 8'($urandom);
      // Port 1 wins when alone, or once it has lost LIMIT cycles in a row.
      w1 = v1 && (!v0 || lost == LIMIT);
      w0 = v0 && !w1;
      cyc(v0, a0, d0, v1, a1, d1, ps);
      total_cnt++; if ({r0, r1} !== {w0, w1}) $display("FAIL rand_grant n%0d: got %b exp %b", n, {r0, r1}, {w0, w1}); else pass_cnt++;
      a = w1 ? a1 : a0; d = w1 ? d1 : d0;
      wr4 = (w0 || w1) && (a == 7'd4);
      m_err = 1'b0;
      if (ps && m_pend && !wr4) begin m_duty = m_shadow; m_pend = 1'b0; end
      if (w0 || w1) begin
        if (a <= 7'd3) m_reg[a[1:0]] = d;
        else if (a == 7'd4) begin
          if (ps) begin m_duty = d; m_pend = 1'b0; end
          else begin m_shadow = d; m_pend = 1'b1; end
        end else begin m_err = 1'b1; m_src = w1; end
      end
      if (v1 && !w1) lost = (lost < LIMIT) ? lost + 1 : LIMIT;
      else           lost = 0;
      total_cnt++; if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_duty})
        $display("FAIL rand_regs n%0d: got %h exp %h", n, {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}, {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_duty}); else pass_cnt++;
      total_cnt++; if ({duty_pending, wr_err, wr_err_src} !== {m_pend, m_err, m_src})
        $display("FAIL rand_flags n%0d: got %b exp %b", n, {duty_pending, wr_err, wr_err_src}, {m_pend, m_err, m_src}); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_direct;
    test_starve;
    test_oor;
    test_duty_stage;
    test_duty_bypass;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cfg_bank_arbiter.md
# cfg_bank_arbiter

Owns the five-entry configuration register bank (output enables, PWM enables, PWM duty cycle) and arbitrates write access to it between two requesters. Port 0 carries writes from the SPI frame decoder; port 1 carries writes from the on-chip sequencer/debug master. The duty-cycle register is double-buffered: writes are staged and committed only on a PWM period boundary, so the PWM generator never sees a mid-period change.

## Interface
- `MAX_ADDR`, default 4: highest valid register address.
- `STARVE_LIMIT`, default 4: number of consecutive lost cycles after which port 1 is forced to win. Legal range 1–15.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req0_valid` input, 1 bit: port 0 (SPI) write request.
- `req0_addr` input, 7 bits: port 0 register address.
- `req0_data` input, 8 bits: port 0 write data.
- `req0_ready` output, 1 bit: port 0 write accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as port 0, for port 1 (sequencer).
- `period_start` input, 1 bit: one-cycle pulse at the start of each PWM period.
- `en_reg_out_7_0` output, 8 bits: address 0.
- `en_reg_out_15_8` output, 8 bits: address 1.
- `en_reg_pwm_7_0` output, 8 bits: address 2.
- `en_reg_pwm_15_8` output, 8 bits: address 3.
- `pwm_duty_cycle` output, 8 bits: committed value of address 4.
- `duty_pending` output, 1 bit: a staged duty value is waiting for commit.
- `wr_err` output, 1 bit: one-cycle pulse when an out-of-range write is discarded.
- `wr_err_src` output, 1 bit: port that caused the last `wr_err`; held until the next error.

## Operation
- **Writes per cycle.** At most one write is granted per cycle. A transfer occurs when `reqN_valid && reqN_ready`.
- **Default arbitration.** Port 0 has fixed priority.
- **Starvation counter** (4 bits, saturating at `STARVE_LIMIT`):
  - Increments each cycle that `req1_valid` is high and port 0 wins.
  - Clears whenever port 1 is granted or `req1_valid` is low.
  - When the counter equals `STARVE_LIMIT` and both ports are valid, port 1 wins and the counter clears.
- **Ready signals.** `reqN_ready` is high only for the granted port; it is never high for a port whose valid is low.
- **Addresses 0–3.** The register updates with `reqN_data`.
- **Address 4.** Data goes to `duty_shadow` and `duty_pending` is set. A newer write overwrites the shadow (last write wins).
- **Out-of-range address** (greater than `MAX_ADDR`):
  - The request is still accepted (ready high).
  - The data is discarded and no register changes.
  - `wr_err` pulses and `wr_err_src` is set to the granted port.
- **Duty commit FSM**, states IDLE and PENDING:
  - IDLE to PENDING: accepted write to address 4.
  - PENDING to IDLE: on `period_start`; `pwm_duty_cycle` takes `duty_shadow`.
  - `period_start` while IDLE: no effect.
- **Simultaneous address-4 write and `period_start`.** The new data is committed directly (bypass), the FSM ends in IDLE, and `duty_pending` is 0.
- **Reset values.** All five registers, `duty_shadow`, `duty_pending`, `wr_err`, `wr_err_src` and the starvation counter reset to 0. The FSM resets to IDLE.
- **Reset mid-operation.** A staged duty value is lost. There is no partial commit.

## Timing
- `reqN_ready` is combinational from both valids and the starvation counter, in the same cycle. There is no other combinational input-to-output path.
- A register write is visible on its output one cycle after the handshake cycle.
- A committed duty value is visible one cycle after `period_start`.
- `wr_err` is registered: it is high for exactly one cycle, the cycle after the offending handshake.
- `duty_pending` is registered and rises one cycle after an accepted address-4 write.
- Sustained throughput is one write per cycle. Port 1 worst-case wait under continuous port 0 traffic is `STARVE_LIMIT` + 1 cycles.

## Structure
- Shared package `spi_regmap_pkg` holds:
  - address constants `ADDR_EN_OUT_LO`=0, `ADDR_EN_OUT_HI`=1, `ADDR_EN_PWM_LO`=2, `ADDR_EN_PWM_HI`=3, `ADDR_DUTY`=4;
  - `MAX_ADDR`;
  - the duty FSM state typedef.
- One sub-module, `wr_priority_arb`: the two-port fixed-priority arbiter plus starvation counter. It outputs `grant[1:0]`.
- Register bank, shadow and FSM stay in the top module.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-traffic → all outputs 0, readies low with valids low; first write after release is accepted.
- **Direct writes.** Port 0 writes addr 2 = 0xA5 → `en_reg_pwm_7_0`=0xA5 next cycle. Port 1 alone writes addr 1 = 0x3C → `en_reg_out_15_8`=0x3C.
- **Starvation**, `STARVE_LIMIT`=4. Port 0 valid every cycle and port 1 valid from cycle 0 → port 1 granted in cycle 4, then again in cycle 9.
- **Out-of-range write.** Port 1 writes addr 7 = 0xFF → ready high, no register changes, `wr_err`=1 for one cycle, `wr_err_src`=1.
- **Duty staging.**
  - Write addr 4 = 0x40, then addr 4 = 0x80 → `pwm_duty_cycle` stays 0 and `duty_pending`=1.
  - Pulse `period_start` → `pwm_duty_cycle`=0x80 and `duty_pending`=0.
- **Duty bypass.** Write addr 4 = 0x22 in the same cycle as `period_start` → `pwm_duty_cycle`=0x22 next cycle, `duty_pending`=0.
